argmax_sel: RTL and testbench

//  Classification stage directly downstream of the FC-layer result buffer writer.

---
 rtl/mnist_pkg.sv | 6 +
 rtl/argmax_sel.sv | 139 +++++++++++++
 tb/tb_argmax_sel.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// mnist_pkg: constants and FSM state type shared by the classification stage.
package mnist_pkg;
    localparam int NUM_CLASS = 10;
    localparam int CLS_WIDTH = 4;
    typedef enum logic {IDLE, ACC} argmax_state_t;
endpackage

// File: rtl/argmax_sel.sv
// argmax_sel: snoops the FC result write stream and picks the arg-max class of each frame.
//   in_en/in_addr/in_data/in_done : one frame of NUM_CLASS signed scores, contiguous addresses
//   label_we/label                : ground truth for the next classified frame
//   pred_valid/class/score/correct: one-cycle result strobe, class/score held until the next one
//   frame_err                     : one-cycle strobe when a malformed frame is discarded
//   img_cnt/correct_cnt           : wrapping frame and correct-prediction counters
module argmax_sel
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_en,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_done,
    input  logic                  label_we,
    input  logic [CLS_WIDTH-1:0]  label,
    output logic                  pred_valid,
    output logic [CLS_WIDTH-1:0]  pred_class,
    output logic [DATA_WIDTH-1:0] pred_score,
    output logic                  pred_correct,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  img_cnt,
    output logic [CNT_WIDTH-1:0]  correct_cnt
);
    argmax_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] max_q, max_d, pred_score_q, pred_score_d, new_max;
    logic [CLS_WIDTH-1:0]  idx_q, idx_d, beat_q, beat_d, label_q, label_d, pred_class_q, pred_class_d, new_idx;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [CNT_WIDTH-1:0]  img_cnt_q, img_cnt_d, correct_cnt_q, correct_cnt_d;
    logic                  label_ok_q, label_ok_d, pred_valid_q, pred_valid_d;
    logic                  pred_correct_q, pred_correct_d, frame_err_q, frame_err_d;
    logic                  last, gt, hit;

    always_comb begin
        last           = beat_q == CLS_WIDTH'(NUM_CLASS - 1);
        // strict compare keeps the lower index on ties
        gt             = $signed(in_data) > $signed(max_q);
        new_max        = gt ? in_data : max_q;
        new_idx        = gt ? beat_q : idx_q;
        hit            = label_ok_q && new_idx == label_q;
        state_d        = state_q;
        max_d          = max_q;
        idx_d          = idx_q;
        beat_d         = beat_q;
        exp_addr_d     = exp_addr_q;
        label_d        = label_q;
        label_ok_d     = label_ok_q;
        pred_valid_d   = 1'b0;
        pred_class_d   = pred_class_q;
        pred_score_d   = pred_score_q;
        pred_correct_d = pred_correct_q;
        frame_err_d    = 1'b0;
        img_cnt_d      = img_cnt_q;
        correct_cnt_d  = correct_cnt_q;
        if (state_q == IDLE) begin
            if (in_en && in_done) begin
                frame_err_d = 1'b1;
            end else if (in_en) begin
                state_d    = ACC;
                max_d      = in_data;
                idx_d      = '0;
                beat_d     = CLS_WIDTH'(1);
                exp_addr_d = in_addr + ADDR_WIDTH'(1);
            end
        end else if (in_en) begin
            // address gap, early done, or missing done all discard the frame
            if (in_addr != exp_addr_q || in_done != last) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else if (last) begin
                state_d        = IDLE;
                pred_valid_d   = 1'b1;
                pred_class_d   = new_idx;
                pred_score_d   = new_max;
                pred_correct_d = hit;
                img_cnt_d      = img_cnt_q + CNT_WIDTH'(1);
                correct_cnt_d  = correct_cnt_q + CNT_WIDTH'(hit);
                label_ok_d     = 1'b0;
            end else begin
                max_d      = new_max;
                idx_d      = new_idx;
                beat_d     = beat_q + CLS_WIDTH'(1);
                exp_addr_d = exp_addr_q + ADDR_WIDTH'(1);
            end
        end
        // a label written alongside the last beat belongs to the next frame
        if (label_we) begin
            label_d    = label;
            label_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            max_q          <= '0;
            idx_q          <= '0;
            beat_q         <= '0;
            exp_addr_q     <= '0;
            label_q        <= '0;
            label_ok_q     <= 1'b0;
            pred_valid_q   <= 1'b0;
            pred_class_q   <= '0;
            pred_score_q   <= '0;
            pred_correct_q <= 1'b0;
            frame_err_q    <= 1'b0;
            img_cnt_q      <= '0;
            correct_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            max_q          <= max_d;
            idx_q          <= idx_d;
            beat_q         <= beat_d;
            exp_addr_q     <= exp_addr_d;
            label_q        <= label_d;
            label_ok_q     <= label_ok_d;
            pred_valid_q   <= pred_valid_d;
            pred_class_q   <= pred_class_d;
            pred_score_q   <= pred_score_d;
            pred_correct_q <= pred_correct_d;
            frame_err_q    <= frame_err_d;
            img_cnt_q      <= img_cnt_d;
            correct_cnt_q  <= correct_cnt_d;
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_class   = pred_class_q;
    assign pred_score   = pred_score_q;
    assign pred_correct = pred_correct_q;
    assign frame_err    = frame_err_q;
    assign img_cnt      = img_cnt_q;
    assign correct_cnt  = correct_cnt_q;
endmodule

// File: tb/tb_argmax_sel.sv
// tb_argmax_sel: randomized frames checked against a behavioural arg-max model.
module tb_argmax_sel;
    logic        clk = 0, rst = 1, in_en = 0, in_done = 0, label_we = 0;
    logic [6:0]  in_addr = 0;
    logic [31:0] in_data = 0;
    logic [3:0]  label = 0;
    logic        pred_valid, pred_correct, frame_err;
    logic [3:0]  pred_class;
    logic [31:0] pred_score;
    logic [15:0] img_cnt, correct_cnt;

    argmax_sel dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
        .in_done(in_done), .label_we(label_we), .label(label),
        .pred_valid(pred_valid), .pred_class(pred_class), .pred_score(pred_score),
        .pred_correct(pred_correct), .frame_err(frame_err),
        .img_cnt(img_cnt), .correct_cnt(correct_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0, fe_cnt = 0, both_cnt = 0;
    logic [36:0] q_res[$], e_res[$];
    logic signed [31:0] sc[10];
    int exp_img = 0, exp_cor = 0;
    logic [3:0] lab = 0;
    bit lab_ok = 0;

    always @(posedge clk) begin
        #1;
        if (pred_valid) q_res.push_back({pred_class, pred_score, pred_correct});
        if (frame_err) fe_cnt++;
        if (frame_err && pred_valid) both_cnt++;
    end

    task model_frame();
        int b;
        bit c;
        b = 0;
        for (int i = 1; i < 10; i++) if (sc[i] > sc[b]) b = i;
        c = lab_ok && 4'(b) == lab;
        e_res.push_back({4'(b), sc[b], c});
        exp_img++;
        if (c) exp_cor++;
        lab_ok = 0;
    endtask

    task set_label(input logic [3:0] l);
        @(negedge clk);
        label_we = 1;
        label = l;
        @(negedge clk);
        label_we = 0;
        lab = l;
        lab_ok = 1;
    endtask

    task idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_en = 0;
            in_done = 0;
            label_we = 0;
        end
    endtask

    task drive_beats(input int a0, n, done_at, skip_at, gaps, lab_at, input logic [3:0] lv);
        for (int i = 0; i < n; i++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            @(negedge clk);
            in_en = 1;
            in_addr = 7'(a0 + i + (i >= skip_at ? 1 : 0));
            in_data = sc[i % 10];
            in_done = (i == done_at);
            label_we = (i == lab_at);
            label = lv;
        end
    endtask

    task rand_scores();
        for (int i = 0; i < 10; i++)
            sc[i] = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 16) - 8;
    endtask

    task test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({pred_valid, pred_class, pred_score, pred_correct, frame_err, img_cnt, correct_cnt} !== '0)
            $display("FAIL reset outputs got %b/%0d/%0d/%b/%b/%0d/%0d want all 0",
                     pred_valid, pred_class, pred_score, pred_correct, frame_err, img_cnt, correct_cnt);
        else passed++;
    endtask

    task test_basic();
        sc = '{5, -3, 7, 2, 100, 9, -50, 0, 1, 4};
        set_label(4);
        drive_beats(0, 10, 9, 99, 0, -1, 0);
        @(negedge clk);
        in_en = 0;
        in_done = 0;
        checks++;
        if ({pred_valid, pred_class, pred_score, pred_correct, img_cnt, correct_cnt} !==
            {1'b1, 4'd4, 32'd100, 1'b1, 16'd1, 16'd1})
            $display("FAIL basic result got v=%b c=%0d s=%0d ok=%b img=%0d cor=%0d want 1/4/100/1/1/1",
                     pred_valid, pred_class, pred_score, pred_correct, img_cnt, correct_cnt);
        else passed++;
        model_frame();
        @(negedge clk);
        checks++;
        if ({pred_valid, pred_class, pred_score} !== {1'b0, 4'd4, 32'd100})
            $display("FAIL basic hold got v=%b c=%0d s=%0d want 0/4/100", pred_valid, pred_class, pred_score);
        else passed++;
        drive_beats(0, 10, 9, 99, 0, -1, 0);
        @(negedge clk);
        in_en = 0;
        in_done = 0;
        checks++;
        if ({pred_valid, pred_correct, img_cnt, correct_cnt} !== {1'b1, 1'b0, 16'd2, 16'd1})
            $display("FAIL nolabel got v=%b ok=%b img=%0d cor=%0d want 1/0/2/1",
                     pred_valid, pred_correct, img_cnt, correct_cnt);
        else passed++;
        model_frame();
        idle(2);
        q_res.delete();
        e_res.delete();
    endtask

    task test_ties_signed();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) sc[i] = (k == 0) ? -1 : i - 10;
            drive_beats(0, 10, 9, 99, 0, -1, 0);
            @(negedge clk);
            in_en = 0;
            in_done = 0;
            checks++;
            if ({pred_valid, pred_class, pred_score} !== {1'b1, k == 0 ? 4'd0 : 4'd9, 32'hFFFF_FFFF})
                $display("FAIL ties_signed%0d got v=%b c=%0d s=%0d want 1/%0d/-1",
                         k, pred_valid, pred_class, $signed(pred_score), k == 0 ? 0 : 9);
            else passed++;
            model_frame();
        end
        idle(2);
        q_res.delete();
        e_res.delete();
    endtask

    task test_back_to_back();
        int fe0;
        logic [3:0] lv;
        fe0 = fe_cnt;
        lv = 4'($urandom_range(0, 9));
        rand_scores();
        set_label(4'($urandom_range(0, 9)));
        drive_beats(120, 10, 9, 99, 0, 9, lv);
        model_frame();
        lab = lv;
        lab_ok = 1;
        rand_scores();
        sc[lv] = 32'h7FFF_FFFF;
        drive_beats(2, 10, 9, 99, 0, -1, 0);
        model_frame();
        idle(3);
        checks++;
        if (q_res.size() != 2 || fe_cnt != fe0)
            $display("FAIL b2b strobes got pv=%0d fe=%0d want pv=2 fe=0", q_res.size(), fe_cnt - fe0);
        else passed++;
        while (q_res.size() > 0 && e_res.size() > 0) begin
            checks++;
            if (q_res[0] !== e_res[0]) $display("FAIL b2b result got %h want %h", q_res[0], e_res[0]);
            else passed++;
            void'(q_res.pop_front());
            void'(e_res.pop_front());
        end
        checks++;
        if ({img_cnt, correct_cnt} !== {16'(exp_img), 16'(exp_cor)})
            $display("FAIL b2b counters got %0d/%0d want %0d/%0d", img_cnt, correct_cnt, exp_img, exp_cor);
        else passed++;
        q_res.delete();
        e_res.delete();
    endtask

    task test_errors();
        int fe0;
        for (int k = 0; k < 3; k++) begin
            fe0 = fe_cnt;
            rand_scores();
            if (k == 0) drive_beats(0, 7, 6, 99, 0, -1, 0);
            else if (k == 1) drive_beats(0, 5, 99, 4, 0, -1, 0);
            else drive_beats(0, 10, 99, 99, 0, -1, 0);
            idle(3);
            checks++;
            if (fe_cnt != fe0 + 1 || q_res.size() != 0 || img_cnt !== 16'(exp_img))
                $display("FAIL err%0d got fe=%0d pv=%0d img=%0d want fe=1 pv=0 img=%0d",
                         k, fe_cnt - fe0, q_res.size(), img_cnt, exp_img);
            else passed++;
            rand_scores();
            drive_beats($urandom_range(0, 127), 10, 9, 99, 0, -1, 0);
            model_frame();
            idle(3);
            checks++;
            if (q_res.size() != 1 || q_res[0] !== e_res[0] || img_cnt !== 16'(exp_img))
                $display("FAIL err%0d recovery got n=%0d res=%h img=%0d want n=1 res=%h img=%0d",
                         k, q_res.size(), q_res.size() ? q_res[0] : 37'h0, img_cnt, e_res[0], exp_img);
            else passed++;
            q_res.delete();
            e_res.delete();
        end
    endtask

    task test_reset_mid_frame();
        int fe0;
        rand_scores();
        drive_beats(0, 6, 99, 99, 0, -1, 0);
        @(negedge clk);
        in_en = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        fe0 = fe_cnt;
        q_res.delete();
        exp_img = 0;
        exp_cor = 0;
        lab_ok = 0;
        checks++;
        if ({pred_valid, pred_class, pred_score, pred_correct, frame_err, img_cnt, correct_cnt} !== '0)
            $display("FAIL midreset outputs got v=%b c=%0d s=%0d img=%0d cor=%0d want all 0",
                     pred_valid, pred_class, pred_score, img_cnt, correct_cnt);
        else passed++;
        idle(3);
        rand_scores();
        drive_beats(0, 10, 9, 99, 0, -1, 0);
        model_frame();
        idle(3);
        checks++;
        if (q_res.size() != 1 || fe_cnt != fe0 || q_res[0] !== e_res[0] || img_cnt !== 16'd1)
            $display("FAIL midreset next got n=%0d fe=%0d res=%h img=%0d want n=1 fe=0 res=%h img=1",
                     q_res.size(), fe_cnt - fe0, q_res.size() ? q_res[0] : 37'h0, img_cnt, e_res[0]);
        else passed++;
        q_res.delete();
        e_res.delete();
    endtask

    task test_random();
        int fe0, lat;
        logic [3:0] lv;
        fe0 = fe_cnt;
        for (int f = 0; f < 12; f++) begin
            rand_scores();
            if ($urandom_range(0, 1) == 1) set_label(4'($urandom_range(0, 9)));
            if ($urandom_range(0, 1) == 1 && lab_ok) sc[lab] = 32'h7FFF_FFFF;
            lat = ($urandom_range(0, 3) == 0) ? 9 : -1;
            lv = 4'($urandom_range(0, 9));
            drive_beats($urandom_range(0, 127), 10, 9, 99, 1, lat, lv);
            model_frame();
            if (lat == 9) begin
                lab = lv;
                lab_ok = 1;
            end
            idle($urandom_range(1, 3));
        end
        idle(2);
        checks++;
        if (q_res.size() != 12 || fe_cnt != fe0)
            $display("FAIL random strobes got pv=%0d fe=%0d want 12/0", q_res.size(), fe_cnt - fe0);
        else passed++;
        while (q_res.size() > 0 && e_res.size() > 0) begin
            checks++;
            if (q_res[0] !== e_res[0]) $display("FAIL random result got %h want %h", q_res[0], e_res[0]);
            else passed++;
            void'(q_res.pop_front());
            void'(e_res.pop_front());
        end
        checks++;
        if ({img_cnt, correct_cnt} !== {16'(exp_img), 16'(exp_cor)} || both_cnt != 0)
            $display("FAIL random counters got %0d/%0d both=%0d want %0d/%0d both=0",
                     img_cnt, correct_cnt, both_cnt, exp_img, exp_cor);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_signed();
        test_back_to_back();
        test_errors();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
